sine_phase_gen: RTL and testbench

Phase-accumulator address generator (NCO) that drives the quarter-wave sine ROM stage. Each sample tick it adds a frequency tuning word to a phase register and presents the ROM read address and the quadrant code the ROM uses for mirroring. The DAC therefore emits a sine at a runtime-programmable frequency instead of a fixed one. Frequency changes take effect only at a phase wrap, so the output waveform stays phase-continuous.

---
 rtl/sine_pkg.sv | 14 +
 rtl/sine_phase_gen_tick_divider.sv | 27 ++
 rtl/sine_phase_gen.sv | 93 +++++++++
 tb/tb_sine_phase_gen.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sine_pkg.sv
// Shared definitions for the sine generation chain (phase gen, quarter-wave ROM, DAC stage).
package sine_pkg;

   localparam int unsigned ADDR_W = 7;
   localparam int unsigned DATA_W = 10;

   typedef enum logic [1:0] {
      PEAK   = 2'b00,
      FALL   = 2'b01,
      TROUGH = 2'b10,
      RISE   = 2'b11
   } quad_t;

endpackage

// File: rtl/sine_phase_gen_tick_divider.sv
// Sample-tick divider: tick is high for one clock out of every DIV clocks.
module tick_divider #(
   parameter int unsigned DIV = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CNT_W-1:0] r_cnt;

   assign tick = (r_cnt == CNT_W'(DIV - 1));

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_cnt <= '0;
      end else if (tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/sine_phase_gen.sv
// NCO phase accumulator producing quarter-wave ROM address and quadrant; tuning changes apply at wrap.
module sine_phase_gen
   import sine_pkg::*;
#(
   parameter int unsigned PHASE_W    = 24,
   parameter int unsigned DIV        = 1,
   parameter int unsigned RESET_TUNE = 32768
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [PHASE_W-1:0] tune_word,
   input  logic               tune_load,
   input  logic               phase_clear,
   output logic [ADDR_W-1:0]  read_address,
   output logic [1:0]         read_state,
   output logic               sample_valid,
   output logic               wrap,
   output logic               tune_pending
);

   logic [PHASE_W-1:0] r_phase;
   logic [PHASE_W-1:0] r_tune_active;
   logic [PHASE_W-1:0] r_tune_next;
   logic               r_pend;
   logic               r_sample_valid;
   logic               r_wrap;

   logic               w_tick;
   logic [PHASE_W:0]   w_sum;
   logic               w_carry;
   logic               w_apply;
   quad_t              w_quad;

   tick_divider #(.DIV(DIV)) u_tick_divider (
      .clk   (clk),
      .reset (reset),
      .clear (phase_clear),
      .tick  (w_tick)
   );

   assign w_sum   = {1'b0, r_phase} + {1'b0, r_tune_active};
   assign w_carry = w_sum[PHASE_W];

   // A zero word never wraps, so it is replaced on the next tick instead of waiting.
   always_comb begin
      w_apply = 1'b0;
      if (phase_clear) begin
         w_apply = r_pend;
      end else if (w_tick) begin
         w_apply = r_pend && (w_carry || (r_tune_active == '0));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_phase        <= '0;
         r_tune_active  <= PHASE_W'(RESET_TUNE);
         r_tune_next    <= '0;
         r_pend         <= 1'b0;
         r_sample_valid <= 1'b0;
         r_wrap         <= 1'b0;
      end else begin
         r_sample_valid <= 1'b0;
         r_wrap         <= 1'b0;
         if (phase_clear) begin
            r_phase        <= '0;
            r_wrap         <= 1'b1;
            r_sample_valid <= 1'b1;
         end else if (w_tick) begin
            r_phase        <= w_sum[PHASE_W-1:0];
            r_wrap         <= w_carry;
            r_sample_valid <= 1'b1;
         end
         if (w_apply) begin
            r_tune_active <= r_tune_next;
            r_pend        <= 1'b0;
         end
         // A load in the same edge as an apply queues the new word behind it.
         if (tune_load) begin
            r_tune_next <= tune_word;
            r_pend      <= 1'b1;
         end
      end
   end

   assign w_quad       = quad_t'(r_phase[PHASE_W-1 -: 2]);
   assign read_state   = w_quad;
   assign read_address = r_phase[PHASE_W-3 -: ADDR_W];
   assign sample_valid = r_sample_valid;
   assign wrap         = r_wrap;
   assign tune_pending = r_pend;

endmodule

// File: tb/tb_sine_phase_gen.sv
// Directed self-checking bench for sine_phase_gen (DIV=1 main instance, DIV=4 divider instance).
module tb_sine_phase_gen;
   import sine_pkg::*;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [23:0]       tune_word = '0;
   logic              tune_load = 1'b0;
   logic              phase_clear = 1'b0;
   logic [ADDR_W-1:0] read_address;
   logic [1:0]        read_state;
   logic              sample_valid, wrap, tune_pending;

   logic [23:0]       tw4 = '0;
   logic              tl4 = 1'b0, pc4 = 1'b0;
   logic [ADDR_W-1:0] addr4;
   logic [1:0]        state4;
   logic              sv4, wrap4, pend4;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sine_phase_gen #(.PHASE_W(24), .DIV(1), .RESET_TUNE(32768)) dut (
      .clk(clk), .reset(reset), .tune_word(tune_word), .tune_load(tune_load),
      .phase_clear(phase_clear), .read_address(read_address), .read_state(read_state),
      .sample_valid(sample_valid), .wrap(wrap), .tune_pending(tune_pending)
   );

   sine_phase_gen #(.PHASE_W(24), .DIV(4), .RESET_TUNE(32768)) dut4 (
      .clk(clk), .reset(reset), .tune_word(tw4), .tune_load(tl4),
      .phase_clear(pc4), .read_address(addr4), .read_state(state4),
      .sample_valid(sv4), .wrap(wrap4), .tune_pending(pend4)
   );

   typedef struct {
      int k;
      int addr;
      int state;
      int wrp;
   } vec_t;

   vec_t vecs [10];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic run_until_wrap(input int step_exp, input int bound);
      int  prev;
      bit  seen;
      prev = int'(read_address);
      seen = 0;
      for (int i = 0; i < bound; i++) begin
         step();
         if (wrap) begin
            seen = 1;
            break;
         end
         chk("pre_wrap_step", (int'(read_address) - prev) & 127, step_exp);
         prev = int'(read_address);
      end
      if (!seen) chk("wrap_timeout", 0, 1);
   endtask

   initial begin
      int k;
      int n;
      vecs[0] = '{1,   1,   0, 0};
      vecs[1] = '{2,   2,   0, 0};
      vecs[2] = '{127, 127, 0, 0};
      vecs[3] = '{128, 0,   1, 0};
      vecs[4] = '{129, 1,   1, 0};
      vecs[5] = '{256, 0,   2, 0};
      vecs[6] = '{384, 0,   3, 0};
      vecs[7] = '{511, 127, 3, 0};
      vecs[8] = '{512, 0,   0, 1};
      vecs[9] = '{513, 1,   0, 0};

      // Reset defaults
      step(); step();
      chk("rst_addr", int'(read_address), 0);
      chk("rst_state", int'(read_state), 0);
      chk("rst_sv", int'(sample_valid), 0);
      chk("rst_wrap", int'(wrap), 0);
      chk("rst_pend", int'(tune_pending), 0);
      chk("rst_addr4", int'(addr4), 0);
      reset = 1'b0;

      // Table-driven sweep through one full period at step 1
      k = 0;
      for (int v = 0; v < 10; v++) begin
         while (k < vecs[v].k) begin
            step();
            k++;
         end
         chk($sformatf("tbl_addr_k%0d", vecs[v].k), int'(read_address), vecs[v].addr);
         chk($sformatf("tbl_state_k%0d", vecs[v].k), int'(read_state), vecs[v].state);
         chk($sformatf("tbl_wrap_k%0d", vecs[v].k), int'(wrap), vecs[v].wrp);
         chk($sformatf("tbl_sv_k%0d", vecs[v].k), int'(sample_valid), 1);
      end

      // Frequency change applied at wrap
      tune_word = 24'h010000;
      tune_load = 1'b1;
      step();
      tune_load = 1'b0;
      chk("fc_addr_load", int'(read_address), 2);
      chk("fc_pend", int'(tune_pending), 1);
      run_until_wrap(1, 600);
      chk("fc_wrap_addr", int'(read_address), 0);
      chk("fc_pend_clr", int'(tune_pending), 0);
      step();
      chk("fc_step2_a", int'(read_address), 2);
      step();
      chk("fc_step2_b", int'(read_address), 4);

      // Zero-word escape
      tune_word = '0;
      tune_load = 1'b1;
      step();
      tune_load = 1'b0;
      chk("zw_addr_load", int'(read_address), 6);
      chk("zw_pend", int'(tune_pending), 1);
      run_until_wrap(2, 300);
      chk("zw_wrap_addr", int'(read_address), 0);
      chk("zw_pend_clr", int'(tune_pending), 0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("zw_frozen_addr", int'(read_address), 0);
         chk("zw_frozen_wrap", int'(wrap), 0);
      end
      tune_word = 24'd32768;
      tune_load = 1'b1;
      step();
      tune_load = 1'b0;
      chk("zw2_addr_load", int'(read_address), 0);
      chk("zw2_pend", int'(tune_pending), 1);
      step();
      chk("zw2_apply_addr", int'(read_address), 0);
      chk("zw2_apply_pend", int'(tune_pending), 0);
      chk("zw2_apply_wrap", int'(wrap), 0);
      step();
      chk("zw2_run_a", int'(read_address), 1);
      step();
      chk("zw2_run_b", int'(read_address), 2);

      // Simultaneous phase_clear and tune_load at address 57
      n = 0;
      while (read_address != 7'd57 && n < 200) begin
         step();
         n++;
      end
      chk("sim_reach57", int'(read_address), 57);
      phase_clear = 1'b1;
      tune_load   = 1'b1;
      tune_word   = 24'h010000;
      step();
      phase_clear = 1'b0;
      tune_load   = 1'b0;
      chk("sim_addr", int'(read_address), 0);
      chk("sim_wrap", int'(wrap), 1);
      chk("sim_sv", int'(sample_valid), 1);
      chk("sim_pend", int'(tune_pending), 1);
      step();
      chk("sim_next_addr", int'(read_address), 1);
      chk("sim_next_wrap", int'(wrap), 0);

      // Reset mid-operation with a word pending
      for (int i = 0; i < 10; i++) step();
      chk("rmid_pend_before", int'(tune_pending), 1);
      reset = 1'b1;
      step();
      chk("rmid_pend", int'(tune_pending), 0);
      chk("rmid_addr", int'(read_address), 0);
      reset = 1'b0;
      step();
      chk("rmid_step_a", int'(read_address), 1);
      step();
      chk("rmid_step_b", int'(read_address), 2);
      chk("rmid_pend_after", int'(tune_pending), 0);

      // Divider instance: one sample every 4 clocks, +1 address per sample
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         step();
         chk($sformatf("div4_sv_c%0d", c), int'(sv4), (c % 4 == 0) ? 1 : 0);
         chk($sformatf("div4_addr_c%0d", c), int'(addr4), c / 4);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
